// File: rtl/srl_fifo_16xw_pkg.sv
// Shared depth/width constants and occupancy codes for the 16-deep SRL FIFO.
package srl_fifo_16xw_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_CW    = 5;
    localparam int FIFO_AW    = 4;

    typedef logic [FIFO_CW-1:0] count_t;
    typedef logic [FIFO_AW-1:0] addr_t;

    localparam count_t CNT_EMPTY = 5'd0;
    localparam count_t CNT_FULL  = 5'd16;

endpackage

// File: rtl/srl_fifo_16xw_srl.sv
// One-bit, 16-deep addressable shift register (SRL16 style); storage is never reset.
module srl_fifo_16xw_srl
    import srl_fifo_16xw_pkg::*;
(
    input  logic  clk,
    input  logic  ce,
    input  logic  d,
    input  addr_t addr,
    output logic  q
);

    logic [FIFO_DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (ce) begin
            sr <= {sr[FIFO_DEPTH-2:0], d};
        end
    end

    assign q = sr[addr];

endmodule

// File: rtl/srl_fifo_16xw.sv
// 16-deep WIDTH-bit FIFO on SRL storage: accept logic, occupancy counter, flags, read register.
// Optional ALMOST_FULL/ALMOST_EMPTY ports are built only when SRL_FIFO_ALMOST_EN is defined.
module srl_fifo_16xw
    import srl_fifo_16xw_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DIN,
    output logic             FULL,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             EMPTY,
    output count_t           COUNT,
    output logic             OVFL,
    output logic             UNFL
`ifdef SRL_FIFO_ALMOST_EN
    ,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY
`endif
);

    logic             wr_acc;
    logic             rd_acc;
    count_t           count_nxt;
    addr_t            rd_addr;
    logic [WIDTH-1:0] rd_tap;

    assign wr_acc  = WR_EN & ~FULL;
    assign rd_acc  = RD_EN & ~EMPTY;
    // Oldest entry sits at COUNT-1; at COUNT=16 the 4-bit wrap gives 15 as required.
    assign rd_addr = COUNT[FIFO_AW-1:0] - 4'd1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        srl_fifo_16xw_srl u_srl (
            .clk  (CLK),
            .ce   (wr_acc),
            .d    (DIN[i]),
            .addr (rd_addr),
            .q    (rd_tap[i])
        );
    end

    always_comb begin
        count_nxt = COUNT;
        if (wr_acc && !rd_acc) begin
            count_nxt = COUNT + 5'd1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = COUNT - 5'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COUNT <= CNT_EMPTY;
            EMPTY <= 1'b1;
            FULL  <= 1'b0;
            DOUT  <= '0;
            VALID <= 1'b0;
            OVFL  <= 1'b0;
            UNFL  <= 1'b0;
        end else begin
            COUNT <= count_nxt;
            EMPTY <= (count_nxt == CNT_EMPTY);
            FULL  <= (count_nxt == CNT_FULL);
            OVFL  <= WR_EN & FULL;
            UNFL  <= RD_EN & EMPTY;
            VALID <= rd_acc;
            if (rd_acc) begin
                DOUT <= rd_tap;
            end
        end
    end

`ifdef SRL_FIFO_ALMOST_EN
    localparam count_t AF_CODE = count_t'(AF_THRESH);
    localparam count_t AE_CODE = count_t'(AE_THRESH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            ALMOST_FULL  <= (count_nxt >= AF_CODE);
            ALMOST_EMPTY <= (count_nxt <= AE_CODE);
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^{AF_THRESH[0], AE_THRESH[0]};
`endif

endmodule
